// File: rtl/pow2_approx_pkg.sv
// Shared types and helpers for the multi-lane base-2 exponent approximator.
package pow2_approx_pkg;

    typedef enum logic {
        MODE_LINEAR = 1'b0,
        MODE_CORR   = 1'b1
    } mode_e;

    localparam int unsigned CORR_SH0 = 2;
    localparam int unsigned CORR_SH1 = 4;
    localparam int unsigned CORR_SH2 = 5;

    localparam int unsigned SH_W = 16;

    typedef struct packed {
        logic [SH_W-1:0] shift;
        logic            sat;
        logic            zero;
    } shift_dec_t;

    // Right-shift amount for the mantissa plus saturate / flush-to-zero flags.
    function automatic shift_dec_t decode_shift(input int ipart, input int max_exp, input int out_w);
        shift_dec_t d;
        int         sh;
        sh      = max_exp - ipart;
        d.shift = SH_W'(sh);
        d.sat   = (ipart > max_exp);
        d.zero  = (sh >= out_w);
        return d;
    endfunction

endpackage

// File: rtl/pow2_lane.sv
// One lane of the 2^x datapath: decode (S0), fraction correction (S1), shift/saturate (S2).
module pow2_lane
    import pow2_approx_pkg::*;
#(
    parameter int unsigned INT_W   = 6,
    parameter int unsigned FRAC_W  = 10,
    parameter int unsigned OUT_W   = 16,
    parameter int          MAX_EXP = 5
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_adv,
    input  logic                      i_mode,
    input  logic [INT_W+FRAC_W-1:0]   i_x,
    output logic [OUT_W-1:0]          o_pow,
    output logic [INT_W+FRAC_W-1:0]   o_x
);

    localparam int unsigned X_W  = INT_W + FRAC_W;
    localparam int unsigned F1_W = FRAC_W + 1;
    localparam int unsigned P_W  = 2 * FRAC_W + 2;
    localparam int unsigned M_W  = FRAC_W + 1;
    localparam logic [F1_W-1:0] ONE_F = {1'b1, {FRAC_W{1'b0}}};

    logic [X_W-1:0]    x_s0_q, x_s1_q, x_s2_q;
    mode_e             mode_s0_q;
    logic [SH_W-1:0]   shift_s0_q, shift_s1_q;
    logic              sat_s0_q, sat_s1_q, zero_s0_q, zero_s1_q;
    logic [FRAC_W-1:0] fc_s1_q;
    logic [OUT_W-1:0]  pow_s2_q;

    shift_dec_t        dec_d;
    logic [F1_W-1:0]   f_ext, g, corr;
    logic [P_W-1:0]    prod;
    logic [FRAC_W-1:0] fc_d;
    logic [M_W-1:0]    mant;
    logic [OUT_W-1:0]  m_aligned, pow_d;

    always_comb begin
        dec_d = decode_shift(int'($signed(i_x[X_W-1:FRAC_W])), MAX_EXP, int'(OUT_W));
    end

    // Second-order correction: f - (g/4 + g/16 + g/32), g = f(1-f) in fraction units.
    always_comb begin
        f_ext = {1'b0, x_s0_q[FRAC_W-1:0]};
        prod  = P_W'(f_ext) * P_W'(ONE_F - f_ext);
        g     = F1_W'(prod >> FRAC_W);
        corr  = (g >> CORR_SH0) + (g >> CORR_SH1) + (g >> CORR_SH2);
        fc_d  = x_s0_q[FRAC_W-1:0];
        if (mode_s0_q == MODE_CORR) begin
            fc_d = FRAC_W'(f_ext - corr);
        end
    end

    assign mant = {1'b1, fc_s1_q};

    generate
        if (OUT_W >= M_W) begin : g_pad
            assign m_aligned = OUT_W'(mant) << (OUT_W - M_W);
        end else begin : g_trunc
            assign m_aligned = OUT_W'(mant >> (M_W - OUT_W));
        end
    endgenerate

    always_comb begin
        pow_d = m_aligned >> shift_s1_q;
        if (zero_s1_q) begin
            pow_d = '0;
        end
        if (sat_s1_q) begin
            pow_d = '1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            x_s0_q     <= '0;
            mode_s0_q  <= MODE_LINEAR;
            shift_s0_q <= '0;
            sat_s0_q   <= 1'b0;
            zero_s0_q  <= 1'b0;
            x_s1_q     <= '0;
            fc_s1_q    <= '0;
            shift_s1_q <= '0;
            sat_s1_q   <= 1'b0;
            zero_s1_q  <= 1'b0;
            x_s2_q     <= '0;
            pow_s2_q   <= '0;
        end else if (i_adv) begin
            x_s0_q     <= i_x;
            mode_s0_q  <= mode_e'(i_mode);
            shift_s0_q <= dec_d.shift;
            sat_s0_q   <= dec_d.sat;
            zero_s0_q  <= dec_d.zero;
            x_s1_q     <= x_s0_q;
            fc_s1_q    <= fc_d;
            shift_s1_q <= shift_s0_q;
            sat_s1_q   <= sat_s0_q;
            zero_s1_q  <= zero_s0_q;
            x_s2_q     <= x_s1_q;
            pow_s2_q   <= pow_d;
        end
    end

    assign o_pow = pow_s2_q;
    assign o_x   = x_s2_q;

endmodule

// File: rtl/pow2_approx_pipe.sv
// Multi-lane 2^x approximator with a shared valid/ready handshake and full back-pressure.
module pow2_approx_pipe
    import pow2_approx_pkg::*;
#(
    parameter int unsigned LANES   = 1,
    parameter int unsigned INT_W   = 6,
    parameter int unsigned FRAC_W  = 10,
    parameter int unsigned OUT_W   = 16,
    parameter int          MAX_EXP = 5
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_valid,
    output logic                              o_ready,
    input  logic                              i_mode,
    input  logic [LANES*(INT_W+FRAC_W)-1:0]   i_x,
    output logic                              o_valid,
    input  logic                              i_ready,
    output logic [LANES*OUT_W-1:0]            o_pow_x,
    output logic [LANES*(INT_W+FRAC_W)-1:0]   o_x_bypass
);

    localparam int unsigned X_W = INT_W + FRAC_W;

    logic v_s0_q, v_s1_q, v_s2_q;
    logic adv;

    // The whole pipe freezes only while a finished beat waits on downstream.
    assign adv     = !v_s2_q || i_ready;
    assign o_ready = adv;
    assign o_valid = v_s2_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v_s0_q <= 1'b0;
            v_s1_q <= 1'b0;
            v_s2_q <= 1'b0;
        end else if (adv) begin
            v_s0_q <= i_valid;
            v_s1_q <= v_s0_q;
            v_s2_q <= v_s1_q;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        pow2_lane #(
            .INT_W   (INT_W),
            .FRAC_W  (FRAC_W),
            .OUT_W   (OUT_W),
            .MAX_EXP (MAX_EXP)
        ) u_lane (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_adv   (adv),
            .i_mode  (i_mode),
            .i_x     (i_x[l*X_W +: X_W]),
            .o_pow   (o_pow_x[l*OUT_W +: OUT_W]),
            .o_x     (o_x_bypass[l*X_W +: X_W])
        );
    end

endmodule

// File: tb/tb_pow2_approx_pipe.sv
// Randomised and directed bench for pow2_approx_pipe (4 lanes) against an arithmetic reference.
module tb_pow2_approx_pipe;

    localparam int LANES   = 4;
    localparam int FRAC_W  = 10;
    localparam int OUT_W   = 16;
    localparam int MAX_EXP = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic        i_mode = 1'b0;
    logic [63:0] i_x = '0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [63:0] o_pow_x;
    logic [63:0] o_x_bypass;

    always #5 clk = ~clk;

    pow2_approx_pipe #(.LANES(LANES)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_mode     (i_mode),
        .i_x        (i_x),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_pow_x    (o_pow_x),
        .o_x_bypass (o_x_bypass)
    );

    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;
    int          stalls = 0;
    logic [63:0] q_pow[$];
    logic [63:0] q_x[$];
    int          q_cyc[$];
    int          q_st[$];
    bit          hold_v = 1'b0;
    logic [63:0] hold_pow, hold_x, last_pow;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // 2^x as an OUT_W-bit value with the binary point after the top bit, scaled by 2^(x-MAX_EXP).
    function automatic logic [15:0] ref_lane(input logic [15:0] x, input logic mode);
        int     xs, f, ip, sh, g, fc;
        longint m;
        xs = int'($signed(x));
        f  = xs & ((1 << FRAC_W) - 1);
        ip = (xs - f) / (1 << FRAC_W);
        if (ip > MAX_EXP) return 16'hFFFF;
        sh = MAX_EXP - ip;
        if (sh >= OUT_W) return 16'h0000;
        fc = f;
        if (mode) begin
            g  = (f * ((1 << FRAC_W) - f)) / (1 << FRAC_W);
            fc = f - (g / 4 + g / 16 + g / 32);
        end
        m = longint'((1 << FRAC_W) + fc) << (OUT_W - 1 - FRAC_W);
        return 16'(m >> sh);
    endfunction

    function automatic logic [63:0] ref_vec(input logic [63:0] x, input logic mode);
        logic [63:0] r;
        r = '0;
        for (int l = 0; l < LANES; l++) r[l*16 +: 16] = ref_lane(x[l*16 +: 16], mode);
        return r;
    endfunction

    // One clock cycle: sample at negedge+1, score handshakes, advance to the next negedge.
    task automatic step(output bit acc);
        logic [63:0] e_pow, e_x;
        int          c0, s0;
        #1;
        check_eq("ready", 64'(o_ready), 64'(!o_valid || i_ready));
        if (hold_v) begin
            check_eq("stall_valid", 64'(o_valid), 64'd1);
            check_eq("stall_pow", o_pow_x, hold_pow);
            check_eq("stall_bypass", o_x_bypass, hold_x);
        end
        hold_v   = o_valid && !i_ready;
        hold_pow = o_pow_x;
        hold_x   = o_x_bypass;
        if (o_valid && !i_ready) stalls++;
        acc = i_valid && (!o_valid || i_ready);
        if (acc) begin
            q_pow.push_back(ref_vec(i_x, i_mode));
            q_x.push_back(i_x);
            q_cyc.push_back(cyc);
            q_st.push_back(stalls);
        end
        if (o_valid && i_ready) begin
            if (q_pow.size() == 0) begin
                check_eq("spurious_beat", 64'd1, 64'd0);
            end else begin
                e_pow = q_pow.pop_front();
                e_x   = q_x.pop_front();
                c0    = q_cyc.pop_front();
                s0    = q_st.pop_front();
                check_eq("pow", o_pow_x, e_pow);
                check_eq("bypass", o_x_bypass, e_x);
                check_eq("latency", 64'(cyc - c0), 64'(3 + stalls - s0));
                last_pow = o_pow_x;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        bit a;
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int i = 0; i < 20 && q_pow.size() != 0; i++) step(a);
        check_eq("drain_empty", 64'(q_pow.size()), 64'd0);
        step(a);
    endtask

    task automatic send_expect(input string tag, input logic [63:0] x, input logic mode,
                               input logic [63:0] exp_pow);
        bit a;
        i_valid  = 1'b1;
        i_x      = x;
        i_mode   = mode;
        i_ready  = 1'b1;
        last_pow = 'x;
        step(a);
        drain();
        check_eq(tag, last_pow, exp_pow);
    endtask

    initial begin
        bit          a;
        int          got;
        logic [15:0] xv;

        #1;
        check_eq("reset_valid", 64'(o_valid), 64'd0);
        check_eq("reset_pow", o_pow_x, 64'd0);
        check_eq("reset_bypass", o_x_bypass, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        send_expect("x_0_lin",     {4{16'h0000}}, 1'b0, {4{16'h0400}});
        send_expect("x_5p5_lin",   {4{16'h1600}}, 1'b0, {4{16'hC000}});
        send_expect("x_5p5_corr",  {4{16'h1600}}, 1'b1, {4{16'hB500}});
        send_expect("x_m10_lin",   {4{16'hD800}}, 1'b0, {4{16'h0001}});
        send_expect("x_m11_zero",  {4{16'hD400}}, 1'b0, {4{16'h0000}});
        send_expect("x_6_sat",     {4{16'h1800}}, 1'b0, {4{16'hFFFF}});
        send_expect("x_m0p5_lin",  {4{16'hFE00}}, 1'b0, {4{16'h0300}});
        send_expect("mixed_lanes", {16'h1800, 16'hD400, 16'h1600, 16'h0000}, 1'b1,
                    {16'hFFFF, 16'h0000, 16'hB500, 16'h0400});

        // 8-beat stream with downstream stalled for 4 cycles mid-stream.
        got = 0;
        for (int c = 0; c < 60 && got < 8; c++) begin
            i_valid = 1'b1;
            i_mode  = 1'(got & 1);
            i_x     = {16'(got * 16'h0123), 16'(16'h1000 - got * 16'h0400), 16'(16'hF000 + got), 16'(got << 8)};
            i_ready = !(c >= 4 && c < 8);
            step(a);
            if (a) got++;
        end
        check_eq("bp_accepted", 64'(got), 64'd8);
        drain();

        // Asynchronous reset with beats in flight.
        i_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            i_valid = 1'b1;
            i_mode  = 1'b0;
            i_x     = {4{16'(16'h0400 * c)}};
            step(a);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid", 64'(o_valid), 64'd0);
        check_eq("arst_pow", o_pow_x, 64'd0);
        check_eq("arst_ready", 64'(o_ready), 64'd1);
        q_pow.delete();
        q_x.delete();
        q_cyc.delete();
        q_st.delete();
        hold_v = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send_expect("post_reset", {4{16'h0000}}, 1'b1, {4{16'h0400}});

        // Random traffic with random back-pressure.
        for (int c = 0; c < 400; c++) begin
            i_valid = ($urandom_range(0, 9) < 7);
            i_ready = ($urandom_range(0, 3) != 0);
            i_mode  = 1'($urandom_range(0, 1));
            for (int l = 0; l < LANES; l++) begin
                xv = 16'($urandom);
                if ($urandom_range(0, 3) != 0) xv[15:10] = 6'(int'($urandom_range(0, 19)) - 12);
                i_x[l*16 +: 16] = xv;
            end
            step(a);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
